// File: rtl/instr_assembler.sv
// Encodes field inputs into 16-bit instruction words, buffers them in a small FIFO and
// writes them to consecutive instruction-memory addresses. Optional macro ASM_CHECKSUM_EN adds a checksum port.
module instr_assembler #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [3:0]  f1,
  input  logic [3:0]  f2,
  input  logic [3:0]  f3,
  input  logic [7:0]  imm8,
  input  logic [11:0] imm12,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        ovf,
`ifdef ASM_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [15:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   OCC_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [FIFO_DEPTH-1:0][15:0] fifo_mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [PW:0]                occ, occ_nxt;
  logic [15:0]                enc_word;
  logic                       push, pop, restart, full;

  assign full    = (occ == OCC_FULL);
  assign push    = in_valid && in_ready;
  assign pop     = mem_ack && mem_req;
  assign restart = start && (state == IDLE || state == DONE);

  always_comb begin
    enc_word = {op, 12'h000};
    case (op)
      4'hA, 4'hB: enc_word = {op, f1, imm8};
      4'hC:       enc_word = {op, f1[2:0], imm12[8:0]};
      4'hD:       enc_word = {op, imm12};
      4'hE, 4'hF: enc_word = {op, 12'h000};
      default:    enc_word = {op, f1, f2, f3};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // HLT is always the last word, so the pop that empties the FIFO in DRAIN retires it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (push && op == 4'hF) state_nxt = DRAIN;
      DRAIN:      if (pop && occ == OCC_ONE) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD) && !full;
    busy      = (state == LOAD) || (state == DRAIN);
    done      = (state == DONE);
    mem_wdata = mem_req ? fifo_mem[rd_ptr] : 16'h0000;
  end

  always_comb begin
    occ_nxt = occ;
    if (restart)          occ_nxt = '0;
    else if (push && !pop) occ_nxt = occ + OCC_ONE;
    else if (pop && !push) occ_nxt = occ - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= BASE_ADDR;
      count    <= 16'h0000;
      ovf      <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      mem_req <= (state_nxt == LOAD || state_nxt == DRAIN) && (occ_nxt != '0);
      if (restart) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        mem_addr <= BASE_ADDR;
        count    <= 16'h0000;
        ovf      <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          mem_addr <= mem_addr + 16'h0001;
          count    <= count + 16'h0001;
          if (mem_addr == 16'hFFFF) ovf <= 1'b1;
        end
      end
    end
  end

`ifdef ASM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       checksum <= 16'h0000;
    else if (restart) checksum <= 16'h0000;
    else if (pop)     checksum <= checksum ^ mem_wdata;
  end
`endif

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: table vectors, hand sequences and random traffic against a queue model.
module tb_instr_assembler;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, mem_ack;
  logic [3:0] op, f1, f2, f3;
  logic [7:0] imm8;
  logic [11:0] imm12;
  logic in_ready, mem_req, busy, done, ovf;
  logic [15:0] mem_addr, mem_wdata, count;
  logic w_in_ready, w_mem_req, w_busy, w_done, w_ovf;
  logic [15:0] w_mem_addr, w_mem_wdata, w_count;
`ifdef ASM_CHECKSUM_EN
  logic [15:0] checksum, w_checksum;
`endif

  always #5 clk = ~clk;

  instr_assembler #(.BASE_ADDR(16'h0000), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .f1(f1), .f2(f2), .f3(f3), .imm8(imm8), .imm12(imm12),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .ovf(ovf),
`ifdef ASM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count));

  instr_assembler #(.BASE_ADDR(16'hFFFF), .FIFO_DEPTH(D)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .f1(f1), .f2(f2), .f3(f3), .imm8(imm8), .imm12(imm12),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ack(mem_ack),
    .busy(w_busy), .done(w_done), .ovf(w_ovf),
`ifdef ASM_CHECKSUM_EN
    .checksum(w_checksum),
`endif
    .count(w_count));

  // reference model: session flags plus a queue of words waiting for memory
  bit loading, draining, m_done, m_ovf, m_wovf;
  logic [15:0] q[$];
  logic [15:0] m_addr, m_waddr, m_cnt, m_csum;
  int nvec = 0, nerr = 0;

  typedef struct {
    logic [3:0] op, f1, f2, f3;
    logic [7:0] imm8;
    logic [11:0] imm12;
    logic [15:0] word;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [15:0] enc(logic [3:0] o, logic [3:0] a, logic [3:0] b,
                                      logic [3:0] c, logic [7:0] i8, logic [11:0] i12);
    if (o <= 4'h9) return {o, a, b, c};
    if (o == 4'hA || o == 4'hB) return {o, a, i8};
    if (o == 4'hC) return {o, a[2:0], i12[8:0]};
    if (o == 4'hD) return {o, i12};
    return {o, 12'h000};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    loading = 0; draining = 0; m_done = 0; m_ovf = 0; m_wovf = 0;
    m_addr = 16'h0000; m_waddr = 16'hFFFF; m_cnt = 0; m_csum = 0;
  endtask

  task automatic model_step();
    bit acc, pop;
    logic [15:0] w;
    acc = in_valid && loading && q.size() < D;
    pop = mem_ack && q.size() != 0;
    if (start && !loading && !draining) begin
      model_reset();
      loading = 1;
      return;
    end
    if (pop) begin
      w = q.pop_front();
      m_csum ^= w;
      if (m_addr == 16'hFFFF) m_ovf = 1;
      if (m_waddr == 16'hFFFF) m_wovf = 1;
      m_addr++; m_waddr++; m_cnt++;
      if (w[15:12] == 4'hF) begin draining = 0; m_done = 1; end
    end
    if (acc) begin
      q.push_back(enc(op, f1, f2, f3, imm8, imm12));
      if (op == 4'hF) begin loading = 0; draining = 1; end
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, loading && q.size() < D);
    chk("mem_req", mem_req, q.size() != 0);
    chk("busy", busy, loading || draining);
    chk("done", done, m_done);
    chk("ovf", ovf, m_ovf);
    chk("count", count, m_cnt);
    chk("mem_addr", mem_addr, m_addr);
    chk("w_mem_addr", w_mem_addr, m_waddr);
    chk("w_ovf", w_ovf, m_wovf);
    if (q.size() != 0) begin
      chk("mem_wdata", mem_wdata, q[0]);
      chk("w_mem_wdata", w_mem_wdata, q[0]);
    end
`ifdef ASM_CHECKSUM_EN
    chk("checksum", checksum, m_csum);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_vec(input vec_t v);
    op = v.op; f1 = v.f1; f2 = v.f2; f3 = v.f3; imm8 = v.imm8; imm12 = v.imm12;
  endtask

  task automatic push_ack(input vec_t v);
    set_vec(v); in_valid = 1; cycle(); in_valid = 0;
    mem_ack = 1; cycle(); mem_ack = 0;
  endtask

  initial begin
    int idx;
    bit acc_pred;
    tbl[0] = '{4'h0, 4'h1, 4'h2, 4'h3, 8'h00, 12'h000, 16'h0123};
    tbl[1] = '{4'hB, 4'h4, 4'h9, 4'h9, 8'h5A, 12'h777, 16'hB45A};
    tbl[2] = '{4'hC, 4'h3, 4'h8, 4'h8, 8'hFF, 12'h1FF, 16'hC7FF};
    tbl[3] = '{4'hD, 4'h6, 4'h6, 4'h6, 8'h11, 12'hABC, 16'hDABC};
    tbl[4] = '{4'h9, 4'hA, 4'hB, 4'hC, 8'h33, 12'h444, 16'h9ABC};
    tbl[5] = '{4'hA, 4'h2, 4'h5, 4'h5, 8'h7E, 12'h555, 16'hA27E};
    tbl[6] = '{4'hC, 4'hF, 4'h1, 4'h1, 8'h00, 12'hE00, 16'hCE00};
    tbl[7] = '{4'hE, 4'h5, 4'h5, 4'h5, 8'hAA, 12'hBBB, 16'hE000};
    tbl[8] = '{4'hF, 4'h7, 4'h7, 4'h7, 8'hCC, 12'hDDD, 16'hF000};

    rst_n = 0; start = 0; in_valid = 0; mem_ack = 0;
    set_vec(tbl[0]);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_w_mem_addr", w_mem_addr, 16'hFFFF);
    chk("rst_count", count, 16'h0);
    check_all();
    rst_n = 1;

    // table: encoding, address sequence and count, ending with HLT
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 9; i++) begin
      set_vec(tbl[i]); in_valid = 1; cycle(); in_valid = 0;
      chk("tbl_word", mem_wdata, tbl[i].word);
      chk("tbl_addr", mem_addr, 16'(i));
      mem_ack = 1; cycle(); mem_ack = 0;
      chk("tbl_count", count, 16'(i + 1));
    end
    chk("tbl_done", done, 16'h1);
    chk("tbl_req_dropped", mem_req, 16'h0);

    // wrap from FFFF on the second instance
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 3; i++) begin
      set_vec(tbl[i == 2 ? 8 : i]); in_valid = 1; cycle(); in_valid = 0;
      chk("wrap_addr", w_mem_addr, i == 0 ? 16'hFFFF : 16'(i - 1));
      mem_ack = 1; cycle(); mem_ack = 0;
    end
    chk("wrap_ovf", w_ovf, 16'h1);
    chk("wrap_done", w_done, 16'h1);
    chk("wrap_count", w_count, 16'd3);
    chk("nowrap_ovf", ovf, 16'h0);

    // stall: FIFO fills, head stays stable, 5th word enters after first ack
    start = 1; cycle(); start = 0;
    idx = 0; in_valid = 1;
    for (int c = 0; c < 7; c++) begin
      set_vec(tbl[idx]);
      acc_pred = loading && q.size() < D;
      cycle();
      if (acc_pred) idx++;
    end
    chk("stall_accepted", 16'(idx), 16'd4);
    chk("stall_in_ready", in_ready, 16'h0);
    chk("stall_wdata", mem_wdata, 16'h0123);
    chk("stall_addr", mem_addr, 16'h0000);
    set_vec(tbl[4]);
    mem_ack = 1; cycle(); mem_ack = 0;
    chk("stall_ready_after_ack", in_ready, 16'h1);
    cycle(); in_valid = 0;
    mem_ack = 1; repeat (4) cycle(); mem_ack = 0;
    chk("stall_count", count, 16'd5);

    // start while loading is ignored
    start = 1; cycle(); start = 0;
    chk("ign_start_count", count, 16'd5);
    chk("ign_start_addr", mem_addr, 16'd5);

    // reset in DRAIN with two words buffered
    set_vec(tbl[0]); in_valid = 1; cycle();
    set_vec(tbl[8]); cycle(); in_valid = 0;
    chk("drain_busy", busy, 16'h1);
    chk("drain_req", mem_req, 16'h1);
    mem_ack = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_mem_req", mem_req, 16'h0);
    chk("arst_busy", busy, 16'h0);
    chk("arst_count", count, 16'h0);
    chk("arst_mem_addr", mem_addr, 16'h0);
    chk("arst_mem_wdata", mem_wdata, 16'h0);
    model_reset();
    @(negedge clk); check_all();
    rst_n = 1; mem_ack = 0;
    cycle();

`ifdef ASM_CHECKSUM_EN
    start = 1; cycle(); start = 0;
    push_ack(tbl[0]); push_ack(tbl[8]);
    chk("checksum_pair", checksum, 16'hF123);
`endif

    // random traffic
    for (int c = 0; c < 800; c++) begin
      start = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 1);
      mem_ack = $urandom_range(0, 1);
      op = 4'($urandom_range(0, 15)); f1 = 4'($urandom); f2 = 4'($urandom); f3 = 4'($urandom);
      imm8 = 8'($urandom); imm12 = 12'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
